// File: rtl/decode_pkg.sv
// decode_pkg: RV32 opcodes, immediate formats and special encodings shared by the decode stage
package decode_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_ECALL = 32'h00000073;
    localparam logic [31:0] INST_MRET  = 32'h30200073;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_SH
    } imm_fmt_t;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: classifies the immediate format of an instruction and builds the extended immediate
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm
);
    always_comb begin
        fmt = FMT_NONE;
        case (inst[6:0])
            OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_IMM:           fmt = (inst[13:12] == 2'b01) ? FMT_SH : FMT_I;
            OP_STORE:         fmt = FMT_S;
            OP_BRANCH:        fmt = FMT_B;
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_JAL:           fmt = FMT_J;
            default:          ;
        endcase
    end

    assign imm = (fmt == FMT_I)  ? XLEN'($signed(inst[31:20])) :
                 (fmt == FMT_SH) ? XLEN'(inst[24:20]) :
                 (fmt == FMT_S)  ? XLEN'($signed({inst[31:25], inst[11:7]})) :
                 (fmt == FMT_B)  ? XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})) :
                 (fmt == FMT_U)  ? XLEN'($signed({inst[31:12], 12'b0})) :
                 (fmt == FMT_J)  ? XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})) :
                 '0;
endmodule

// File: rtl/idu_ibuf_decode.sv
// idu_ibuf_decode: instruction FIFO between IFU and EXU that presents its head entry fully decoded
module idu_ibuf_decode
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_inst,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic [XLEN-1:0]  out_imm,
    output logic [11:0]      out_csr_addr,
    output logic             out_r_wen,
    output logic             out_csr_wen,
    output logic             out_mem_ren,
    output logic             out_mem_wen,
    output logic             out_branch,
    output logic             out_jump,
    output logic             out_ecall,
    output logic             out_mret,
    output logic             out_illegal,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem_inst [DEPTH];
    logic [XLEN-1:0]  mem_pc   [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             push, pop;

    assign in_ready  = count != CNT_W'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_inst[wr_ptr] <= in_inst;
            mem_pc[wr_ptr]   <= in_pc;
        end
    end

    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    imm_fmt_t        fmt;
    logic            legal, csr, wb, ok;

    assign inst   = mem_inst[rd_ptr];
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (inst),
        .fmt  (fmt),
        .imm  (imm)
    );

    assign legal = (inst != '0) && (opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                                   OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_SYSTEM});
    assign csr   = (opcode == OP_SYSTEM) && (funct3 != 3'd0);
    assign wb    = csr || (opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP});
    assign ok    = out_valid && legal;

    assign out_r_wen   = ok && wb && (inst[11:7] != 5'd0);
    assign out_csr_wen = ok && csr;
    assign out_mem_ren = ok && (opcode == OP_LOAD);
    assign out_mem_wen = ok && (fmt == FMT_S);
    assign out_branch  = ok && (fmt == FMT_B);
    assign out_jump    = ok && ((fmt == FMT_J) || (opcode == OP_JALR));
    assign out_ecall   = out_valid && (inst == INST_ECALL);
    assign out_mret    = out_valid && (inst == INST_MRET);
    assign out_illegal = out_valid && !legal;

    // Data outputs are zeroed when empty so stale storage never leaks downstream
    assign out_pc       = out_valid ? mem_pc[rd_ptr] : '0;
    assign out_inst     = out_valid ? inst : '0;
    assign out_rs1      = out_valid ? inst[19:15] : '0;
    assign out_rs2      = out_valid ? inst[24:20] : '0;
    assign out_rd       = out_valid ? inst[11:7] : '0;
    assign out_funct3   = out_valid ? funct3 : '0;
    assign out_imm      = out_valid ? imm : '0;
    assign out_csr_addr = out_valid ? inst[31:20] : '0;
endmodule

// File: tb/tb_idu_ibuf_decode.sv
// tb_idu_ibuf_decode: scoreboard bench for the decode-stage instruction buffer
module tb_idu_ibuf_decode;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_inst = 0;
    logic [31:0] in_pc = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] out_pc, out_inst, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic [11:0] out_csr_addr;
    logic        out_r_wen, out_csr_wen, out_mem_ren, out_mem_wen;
    logic        out_branch, out_jump, out_ecall, out_mret, out_illegal;
    logic [2:0]  count;

    idu_ibuf_decode dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_imm(out_imm), .out_csr_addr(out_csr_addr), .out_r_wen(out_r_wen),
        .out_csr_wen(out_csr_wen), .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
        .out_branch(out_branch), .out_jump(out_jump), .out_ecall(out_ecall),
        .out_mret(out_mret), .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, inst, imm;
        logic [4:0]  rd;
        logic        r_wen, branch, ecall, illegal;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, inst, imm, input logic [4:0] rd,
                                input logic r_wen, branch, ecall, illegal);
        exp_t e;
        e.pc = pc; e.inst = inst; e.imm = imm; e.rd = rd;
        e.r_wen = r_wen; e.branch = branch; e.ecall = ecall; e.illegal = illegal;
        return e;
    endfunction

    // Monitor: every handshake-out is compared against the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc %h expected none", out_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_inst", out_inst, e.inst);
                chk("sb_imm", out_imm, e.imm);
                chk("sb_rd", 32'(out_rd), 32'(e.rd));
                chk("sb_r_wen", 32'(out_r_wen), 32'(e.r_wen));
                chk("sb_branch", 32'(out_branch), 32'(e.branch));
                chk("sb_ecall", 32'(out_ecall), 32'(e.ecall));
                chk("sb_illegal", 32'(out_illegal), 32'(e.illegal));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_raw(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1; in_pc = pc; in_inst = inst;
        step();
        in_valid = 0;
    endtask

    task automatic push1(input exp_t e);
        sb.push_back(e);
        push_raw(e.pc, e.inst);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_r_wen", 32'(out_r_wen), 0);
        chk("rst_imm", out_imm, 0);
        rst_n = 1;
        step();

        // addi x1,x0,-1: visible one cycle after the push
        push1(mk(32'h80000000, 32'hFFF00093, 32'hFFFFFFFF, 5'd1, 1, 0, 0, 0));
        chk("lat_out_valid", 32'(out_valid), 1);
        chk("lat_imm", out_imm, 32'hFFFFFFFF);
        chk("lat_rd", 32'(out_rd), 1);
        chk("lat_r_wen", 32'(out_r_wen), 1);
        chk("lat_pc", out_pc, 32'h80000000);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("drain1_count", 32'(count), 0);

        // fill to full with decode vectors
        push1(mk(32'h0, 32'hFE000EE3, 32'hFFFFFFFC, 5'd29, 0, 1, 0, 0));
        push1(mk(32'h4, 32'h00000073, 32'h0, 5'd0, 0, 0, 1, 0));
        push1(mk(32'h8, 32'h00000537, 32'h0, 5'd10, 1, 0, 0, 0));
        push1(mk(32'hC, 32'h00000013, 32'h0, 5'd0, 0, 0, 0, 0));
        chk("full_count", 32'(count), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        in_valid = 1; in_pc = 32'h10; in_inst = 32'hFFFFFFFF;
        step();
        chk("full_hold_count", 32'(count), 4);
        out_ready = 1;
        chk("full_pop_in_ready", 32'(in_ready), 0);
        step();
        chk("full_pop_count", 32'(count), 3);
        in_valid = 0;
        chk("full_pop_in_ready_next", 32'(in_ready), 1);
        repeat (3) step();
        out_ready = 0;
        chk("full_drain_count", 32'(count), 0);

        // pointer wrap: one primer entry then 8 simultaneous push/pop pairs
        push1(mk(32'h1000, 32'h00000093, 32'h0, 5'd1, 1, 0, 0, 0));
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            exp_t e;
            e = mk(32'h1000 + 32'(4 * i), (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13,
                   32'(i), 5'(i + 1), 1, 0, 0, 0);
            sb.push_back(e);
            in_valid = 1; in_pc = e.pc; in_inst = e.inst;
            step();
            chk("wrap_count", 32'(count), 1);
        end
        in_valid = 0;
        step();
        out_ready = 0;
        chk("wrap_drain_count", 32'(count), 0);

        // illegal all-ones word
        push1(mk(32'h2000, 32'hFFFFFFFF, 32'h0, 5'd31, 0, 0, 0, 1));
        chk("ill_flag", 32'(out_illegal), 1);
        out_ready = 1;
        step();
        out_ready = 0;

        // flush with a concurrent offer: the offered entry must vanish
        push_raw(32'h100, 32'h00100093);
        push_raw(32'h104, 32'h00200093);
        chk("pre_flush_count", 32'(count), 2);
        flush = 1; in_valid = 1; in_pc = 32'h108; in_inst = 32'h00300093;
        chk("flush_in_ready", 32'(in_ready), 1);
        step();
        flush = 0; in_valid = 0;
        chk("flush_count", 32'(count), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        push1(mk(32'h200, 32'h00500113, 32'h5, 5'd2, 1, 0, 0, 0));
        out_ready = 1;
        step();
        out_ready = 0;
        chk("post_flush_count", 32'(count), 0);

        // asynchronous reset mid-stream
        push_raw(32'h300, 32'h00100093);
        push_raw(32'h304, 32'h00100093);
        push_raw(32'h308, 32'h00100093);
        chk("pre_rst_count", 32'(count), 3);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_r_wen", 32'(out_r_wen), 0);
        step();
        rst_n = 1;
        step();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
